// File: rtl/sseg_scan_ctrl_pkg.sv
// Shared register map, CTRL/STATUS bit positions and FSM encoding for the
// four-digit seven-segment scan controller.
package sseg_scan_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_RAW      = 1;
    localparam int CTRL_MASK_LSB = 4;
    localparam logic [7:0] CTRL_WMASK = 8'hF3;

    localparam int STAT_SCAN      = 2;
    localparam int STAT_FRAME_LSB = 16;

    localparam int DATA_DP_LSB = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } state_t;

endpackage

// File: rtl/sseg_decoder.sv
// Hex nibble to active-high seven-segment pattern, bit order gfedcba.
module sseg_decoder (
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h00;
        case (i_hex)
            4'h0: o_seg = 7'h3F;
            4'h1: o_seg = 7'h06;
            4'h2: o_seg = 7'h5B;
            4'h3: o_seg = 7'h4F;
            4'h4: o_seg = 7'h66;
            4'h5: o_seg = 7'h6D;
            4'h6: o_seg = 7'h7D;
            4'h7: o_seg = 7'h07;
            4'h8: o_seg = 7'h7F;
            4'h9: o_seg = 7'h6F;
            4'hA: o_seg = 7'h77;
            4'hB: o_seg = 7'h7C;
            4'hC: o_seg = 7'h39;
            4'hD: o_seg = 7'h5E;
            4'hE: o_seg = 7'h79;
            4'hF: o_seg = 7'h71;
            default: o_seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed seven-segment controller with a native-bus register
// interface, per-slot blanking and frame-atomic data updates.
module sseg_scan_ctrl
    import sseg_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [1:0]  address,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [7:0]  CA,
    output logic [3:0]  AN
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_BLANK_END = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] CNT_SLOT_END  = CW'(SCAN_DIV - 1);

    logic          r_ready;
    logic [31:0]   r_rdata;
    logic [31:0]   r_shadow;
    logic [31:0]   r_active;
    logic [7:0]    r_ctrl;

    state_t        r_state, w_nxt_state;
    logic [CW-1:0] r_cnt, w_nxt_cnt;
    logic [1:0]    r_digit, w_nxt_digit;
    logic [15:0]   r_frame, w_nxt_frame;
    logic          w_load;
    logic [7:0]    r_ca;
    logic [3:0]    r_an;

    logic          w_acc, w_wr;
    logic [31:0]   w_status, w_rd;

    assign w_acc = valid & ~r_ready;
    assign w_wr  = w_acc & (wstrb != 4'h0);

    always_comb begin
        w_status = '0;
        w_status[1:0] = r_digit;
        w_status[STAT_SCAN] = (r_state != ST_IDLE);
        w_status[STAT_FRAME_LSB +: 16] = r_frame;
        w_rd = '0;
        case (address)
            ADDR_DATA:   w_rd = r_shadow;
            ADDR_CTRL:   w_rd = {24'h0, r_ctrl};
            ADDR_STATUS: w_rd = w_status;
            default:     w_rd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready  <= 1'b0;
            r_rdata  <= '0;
            r_shadow <= '0;
            r_active <= '0;
            r_ctrl   <= '0;
        end else begin
            r_ready <= w_acc;
            r_rdata <= w_acc ? w_rd : '0;
            if (w_wr && address == ADDR_DATA) begin
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) r_shadow[8*b +: 8] <= wdata[8*b +: 8];
            end
            if (w_wr && address == ADDR_CTRL && wstrb[0])
                r_ctrl <= wdata[7:0] & CTRL_WMASK;
            // Active copy only at a digit-0 slot start keeps every frame coherent.
            if (w_load) r_active <= r_shadow;
        end
    end

    assign ready = r_ready;
    assign rdata = r_rdata;

    // One counter spans the whole slot: blank for the first BLANK_CYC counts, then on.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt + 1'b1;
        w_nxt_digit = r_digit;
        w_nxt_frame = r_frame;
        w_load      = 1'b0;
        if (!r_ctrl[CTRL_EN]) begin
            w_nxt_state = ST_IDLE;
            w_nxt_cnt   = '0;
            w_nxt_digit = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_nxt_state = ST_BLANK;
                    w_nxt_cnt   = '0;
                    w_nxt_digit = '0;
                    w_load      = 1'b1;
                end
                ST_BLANK: begin
                    if (r_cnt == CNT_BLANK_END) w_nxt_state = ST_ON;
                end
                ST_ON: begin
                    if (r_cnt == CNT_SLOT_END) begin
                        w_nxt_state = ST_BLANK;
                        w_nxt_cnt   = '0;
                        w_nxt_digit = r_digit + 2'd1;
                        if (r_digit == 2'd3) begin
                            w_nxt_frame = r_frame + 16'd1;
                            w_load      = 1'b1;
                        end
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_cnt   = '0;
                    w_nxt_digit = '0;
                end
            endcase
        end
    end

    logic [3:0] w_nib, w_dp, w_mask;
    logic [6:0] w_seg;
    logic [7:0] w_pat;
    logic       w_on;

    assign w_nib  = r_active[{1'b0, w_nxt_digit, 2'b00} +: 4];
    assign w_dp   = r_active[DATA_DP_LSB +: 4];
    assign w_mask = r_ctrl[CTRL_MASK_LSB +: 4];

    sseg_decoder u_dec (
        .i_hex (w_nib),
        .o_seg (w_seg)
    );

    // Outputs are registered from next-state so they line up with the FSM.
    assign w_pat = r_ctrl[CTRL_RAW] ? r_active[{w_nxt_digit, 3'b000} +: 8]
                                    : {w_dp[w_nxt_digit], w_seg};
    assign w_on  = (w_nxt_state == ST_ON) && w_mask[w_nxt_digit];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_digit <= '0;
            r_frame <= '0;
            r_ca    <= 8'hFF;
            r_an    <= 4'hF;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_digit <= w_nxt_digit;
            r_frame <= w_nxt_frame;
            r_ca    <= w_on ? ~w_pat : 8'hFF;
            r_an    <= w_on ? ~(4'b0001 << w_nxt_digit) : 4'hF;
        end
    end

    assign CA = r_ca;
    assign AN = r_an;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2 (32-cycle frame).
module tb_sseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [1:0]  address = 2'd0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] rdata;
    logic        ready;
    logic [7:0]  CA;
    logic [3:0]  AN;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] q, q2;

    sseg_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .address(address),
        .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .ready(ready),
        .CA(CA), .AN(AN)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, want);
        end
    endtask

    // Called at a negedge; one access, returns two negedges later with the bus idle.
    task automatic bus(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] r);
        valid = 1'b1; address = a; wdata = d; wstrb = s;
        @(posedge clk); #1;
        valid = 1'b0; wstrb = 4'h0;
        chk("ready_hi", 32'(ready), 32'd1);
        r = rdata;
        @(negedge clk);
        @(posedge clk); #1;
        chk("ready_lo", 32'(ready), 32'd0);
        chk("rdata_idle", rdata, 32'd0);
        @(negedge clk);
    endtask

    // Checks one 32-cycle frame starting at the current negedge (digit 0, count 0).
    task automatic chk_frame(input logic [31:0] ca_b, input logic [3:0] msk);
        int d, ph;
        logic [3:0] an_e;
        logic [7:0] ca_e;
        for (int i = 0; i < 32; i++) begin
            d = i / 8;
            ph = i % 8;
            if (ph < 2 || !msk[d]) begin
                an_e = 4'hF;
                ca_e = 8'hFF;
            end else begin
                an_e = ~(4'b0001 << d);
                ca_e = ca_b[8*d +: 8];
            end
            chk($sformatf("AN[%0d]", i), 32'(AN), 32'(an_e));
            chk($sformatf("CA[%0d]", i), 32'(CA), 32'(ca_e));
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_CA", 32'(CA), 32'hFF);
        chk("rst_AN", 32'(AN), 32'hF);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        bus(2'd0, 0, 4'h0, q); chk("rst_DATA", q, 32'd0);
        bus(2'd1, 0, 4'h0, q); chk("rst_CTRL", q, 32'd0);
        bus(2'd2, 0, 4'h0, q); chk("rst_STATUS", q, 32'd0);

        // Byte strobes, read-only and unmapped addresses
        bus(2'd0, 32'h11223344, 4'hF, q);
        bus(2'd0, 32'hAABBCCDD, 4'h5, q);
        bus(2'd0, 0, 4'h0, q); chk("wstrb_DATA", q, 32'h11BB33DD);
        bus(2'd2, 32'hFFFFFFFF, 4'hF, q);
        bus(2'd3, 32'hFFFFFFFF, 4'hF, q);
        bus(2'd2, 0, 4'h0, q); chk("ro_STATUS", q, 32'd0);
        bus(2'd1, 32'hFFFFFFFF, 4'hE, q);
        bus(2'd1, 0, 4'h0, q); chk("wstrb_CTRL", q, 32'd0);

        // Hex scan of 0x0F10
        bus(2'd0, 32'h00000F10, 4'hF, q);
        bus(2'd1, 32'h000000F1, 4'hF, q);
        chk_frame(32'hC08EF9C0, 4'hF);

        // DATA written during digit 1 ON lands only at the next frame
        fork
            chk_frame(32'hC08EF9C0, 4'hF);
            begin
                repeat (11) @(negedge clk);
                bus(2'd0, 32'h00051234, 4'hF, q);
            end
        join
        chk_frame(32'hF924B019, 4'hF);

        // Mask 0101 keeps slot timing
        fork
            chk_frame(32'hF924B019, 4'h5);
            bus(2'd1, 32'h00000051, 4'hF, q);
        join
        chk_frame(32'hF924B019, 4'h5);

        // Disable mid-ON, then re-enable from digit 0 with reloaded data
        repeat (4) @(negedge clk);
        chk("pre_dis_AN", 32'(AN), 32'hE);
        bus(2'd1, 32'h00000000, 4'hF, q);
        chk("dis_AN", 32'(AN), 32'hF);
        chk("dis_CA", 32'(CA), 32'hFF);
        bus(2'd2, 0, 4'h0, q);
        chk("dis_scan", q & 32'h7, 32'd0);
        bus(2'd0, 32'h00000F10, 4'hF, q);
        bus(2'd1, 32'h000000F1, 4'hF, q);
        chk_frame(32'hC08EF9C0, 4'hF);

        // Raw mode
        bus(2'd1, 32'h00000000, 4'hF, q);
        bus(2'd0, 32'h80FF0001, 4'hF, q);
        bus(2'd1, 32'h000000F3, 4'hF, q);
        chk_frame(32'h7F00FFFE, 4'hF);

        // Asynchronous reset mid-slot
        repeat (3) @(negedge clk);
        chk("pre_rst_AN", 32'(AN), 32'hE);
        rst_n = 1'b0;
        #1;
        chk("arst_CA", 32'(CA), 32'hFF);
        chk("arst_AN", 32'(AN), 32'hF);
        chk("arst_ready", 32'(ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus(2'd2, 0, 4'h0, q); chk("arst_STATUS", q, 32'd0);
        bus(2'd0, 0, 4'h0, q2); chk("arst_DATA", q2, 32'd0);

        // Four frames then frame count
        bus(2'd0, 32'h00000F10, 4'hF, q);
        bus(2'd1, 32'h000000F1, 4'hF, q);
        repeat (4) chk_frame(32'hC08EF9C0, 4'hF);
        bus(2'd2, 0, 4'h0, q); chk("frames", q, 32'h00040004);
        bus(2'd3, 0, 4'h0, q); chk("addr3", q, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
